// File: rtl/cordic_dispatch_pkg.sv
// Shared FSM encoding, function codes and command layout for the CORDIC dispatcher.
package cordic_dispatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] FUNC_ARCTAN = 4'h0;
    localparam logic [3:0] FUNC_MAG    = 4'h1;
    localparam logic [3:0] FUNC_IDLE   = 4'hF;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  func;
    } cmd_t;

    function automatic logic func_legal(input logic [3:0] f);
        return f <= FUNC_MAG;
    endfunction

endpackage

// File: rtl/cordic_cmd_fifo.sv
// Command FIFO: DEPTH entries, pointers carry an extra wrap bit to tell full from empty.
module cordic_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr == r_rd);
    assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign dout      = r_mem[r_rd[AW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cordic_dispatch.sv
// Queues CORDIC commands, issues them one at a time to a shared CORDIC unit
// and returns results (or error responses) strictly in command order.
module cordic_dispatch
    import cordic_dispatch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic [3:0]  in_func,
    output logic        cu_st,
    output logic [15:0] cu_x,
    output logic [15:0] cu_y,
    output logic [3:0]  cu_func,
    input  logic        cu_done,
    input  logic [31:0] cu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_func,
    output logic        out_err,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] L_QUAL = CW'(2);
    localparam logic [CW-1:0] L_TMO  = CW'(TIMEOUT);

    state_t         r_state;
    state_t         w_next;
    logic [15:0]    r_x;
    logic [15:0]    r_y;
    logic [3:0]     r_func;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_data;
    logic           r_err;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_qual;
    logic           w_tmo;
    logic [35:0]    w_head_bits;
    cmd_t           w_head;
    cmd_t           w_in;

    assign w_in     = cmd_t'({in_x, in_y, in_func});
    assign w_head   = cmd_t'(w_head_bits);
    assign in_ready = rst_n && !w_full;
    assign w_push   = in_valid && in_ready;

    cordic_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_in),
        .pop   (w_pop),
        .dout  (w_head_bits),
        .full  (w_full),
        .empty (w_empty)
    );

    // The first two WAIT cycles may still see the previous operation's done level.
    assign w_qual = (r_state == S_WAIT) && cu_done && (r_cnt >= L_QUAL);
    assign w_tmo  = (r_state == S_WAIT) && (r_cnt == L_TMO);

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !out_valid) begin
                    w_pop  = 1'b1;
                    w_next = func_legal(w_head.func) ? S_ISSUE : S_HOLD;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_qual || w_tmo) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_func <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_x    <= w_head.x;
                r_y    <= w_head.y;
                r_func <= w_head.func;
                if (!func_legal(w_head.func)) begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end
            end
            if (r_state == S_ISSUE)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
            if (w_qual) begin
                r_data <= cu_result;
                r_err  <= 1'b0;
            end else if (w_tmo) begin
                r_data <= '0;
                r_err  <= 1'b1;
            end
        end
    end

    assign cu_st     = (r_state == S_ISSUE);
    assign cu_x      = r_x;
    assign cu_y      = r_y;
    assign cu_func   = (r_state == S_ISSUE || r_state == S_WAIT) ? r_func : FUNC_IDLE;
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_data;
    assign out_func  = r_func;
    assign out_err   = r_err;
    assign busy      = !w_empty || (r_state != S_IDLE);

endmodule
